// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between instr_fetch_unit (master) and memory (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC register plus req/ack instruction fetch FSM feeding the control unit.
// Optional request watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                en_fetch,
  input  logic                en_pc_pulse,
  input  logic [1:0]          pc_ctrl,
  input  logic [ADDR_W-1:0]   offset_addr,
  instr_fetch_unit_if.master  mem,
  output logic [DATA_W-1:0]   ins,
  output logic                en_ram_out,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                fetch_ovf,
  output logic                fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic              en_ram_out_q, en_ram_out_d;
  logic              busy_q, busy_d;
  logic              fetch_ovf_q, fetch_ovf_d;
  logic [ADDR_W-1:0] offset_sext;

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            fetch_err_q, fetch_err_d;
`endif

  // offset is already ADDR_W wide, so sign extension to ADDR_W is the identity
  assign offset_sext = offset_addr;

  always_comb begin
    pc_d = pc_q;
    if (en && en_pc_pulse) begin
      unique case (pc_ctrl)
        2'b00: pc_d = pc_q;
        2'b01: pc_d = pc_q + ADDR_W'(1);
        2'b10: pc_d = offset_addr;
        2'b11: pc_d = pc_q + offset_sext;
        default: pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    ins_d        = ins_q;
    en_ram_out_d = 1'b0;
    busy_d       = busy_q;
    fetch_ovf_d  = fetch_ovf_q;
`ifdef FETCH_TIMEOUT_EN
    wdog_d       = wdog_q;
    fetch_err_d  = fetch_err_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (en && en_fetch) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          mem_addr_d = pc_q;
`ifdef FETCH_TIMEOUT_EN
          wdog_d     = '0;
`endif
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      REQ: begin
        if (en_fetch) fetch_ovf_d = 1'b1;
        if (mem.mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          busy_d       = 1'b0;
          ins_d        = mem.mem_rdata;
          en_ram_out_d = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          busy_d       = 1'b0;
          ins_d        = '0;
          en_ram_out_d = 1'b1;
          fetch_err_d  = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= ADDR_W'(RESET_PC);
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      ins_q        <= '0;
      en_ram_out_q <= 1'b0;
      busy_q       <= 1'b0;
      fetch_ovf_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wdog_q       <= '0;
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      ins_q        <= ins_d;
      en_ram_out_q <= en_ram_out_d;
      busy_q       <= busy_d;
      fetch_ovf_q  <= fetch_ovf_d;
`ifdef FETCH_TIMEOUT_EN
      wdog_q       <= wdog_d;
      fetch_err_q  <= fetch_err_d;
`endif
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign ins          = ins_q;
  assign en_ram_out   = en_ram_out_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign fetch_ovf    = fetch_ovf_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err    = fetch_err_q;
`else
  assign fetch_err    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       en_fetch = 1'b0;
  logic       en_pc_pulse = 1'b0;
  logic [1:0] pc_ctrl = 2'b00;
  logic [7:0] offset_addr = 8'h00;
  logic [15:0] ins;
  logic       en_ram_out;
  logic [7:0] pc;
  logic       busy;
  logic       fetch_ovf;
  logic       fetch_err;

  int checks = 0;
  int errors = 0;
  int n;

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) mem_if ();

  instr_fetch_unit #(
    .ADDR_W(8), .DATA_W(16), .RESET_PC(0), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .en_fetch(en_fetch),
    .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl), .offset_addr(offset_addr),
    .mem(mem_if), .ins(ins), .en_ram_out(en_ram_out), .pc(pc),
    .busy(busy), .fetch_ovf(fetch_ovf), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pc(input logic [7:0] v);
    en_pc_pulse = 1'b1; pc_ctrl = 2'b10; offset_addr = v;
    cyc();
    en_pc_pulse = 1'b0;
  endtask

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    cyc(); cyc();
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", mem_if.mem_req, 1'b0);
    chk("rst_addr", mem_if.mem_addr, 8'h00);
    chk("rst_ins", ins, 16'h0000);
    chk("rst_flags", {en_ram_out, busy, fetch_ovf, fetch_err}, 4'b0000);
    rst = 1'b1;
    cyc();

    // Basic fetch, ack in first REQ cycle
    en = 1'b1; en_fetch = 1'b1;
    cyc();
    en_fetch = 1'b0;
    chk("f1_req", {mem_if.mem_req, busy}, 2'b11);
    chk("f1_addr", mem_if.mem_addr, 8'h00);
    chk("f1_noval", en_ram_out, 1'b0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h1A05;
    cyc();
    mem_if.mem_ack = 1'b0;
    chk("f1_valid", {en_ram_out, mem_if.mem_req, busy}, 3'b100);
    chk("f1_ins", ins, 16'h1A05);
    cyc();
    chk("f1_pulse_end", {en_ram_out, busy}, 2'b00);
    chk("f1_ins_hold", ins, 16'h1A05);

    // PC arithmetic
    set_pc(8'h10);
    chk("pc_abs10", pc, 8'h10);
    en_pc_pulse = 1'b1; pc_ctrl = 2'b01; cyc();
    chk("pc_inc", pc, 8'h11);
    pc_ctrl = 2'b10; offset_addr = 8'h80; cyc();
    chk("pc_abs80", pc, 8'h80);
    pc_ctrl = 2'b11; offset_addr = 8'hFE; cyc();
    chk("pc_rel_neg", pc, 8'h7E);
    pc_ctrl = 2'b00; cyc();
    chk("pc_hold", pc, 8'h7E);
    en = 1'b0; pc_ctrl = 2'b01; cyc();
    chk("pc_en0", pc, 8'h7E);
    en = 1'b1; pc_ctrl = 2'b10; offset_addr = 8'hFF; cyc();
    pc_ctrl = 2'b01; cyc();
    chk("pc_wrap_inc", pc, 8'h00);
    pc_ctrl = 2'b11; offset_addr = 8'hFF; cyc();
    chk("pc_wrap_rel", pc, 8'hFF);
    en_pc_pulse = 1'b0;

    // Simultaneous fetch and PC update: fetch uses old PC
    set_pc(8'h20);
    en_fetch = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b01;
    cyc();
    en_fetch = 1'b0; en_pc_pulse = 1'b0;
    chk("sim_addr", mem_if.mem_addr, 8'h20);
    chk("sim_pc", pc, 8'h21);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h2222;
    cyc();
    mem_if.mem_ack = 1'b0;
    chk("sim_valid", en_ram_out, 1'b1);
    cyc();

    // Delayed ack with a dropped second fetch
    en_fetch = 1'b1; cyc(); en_fetch = 1'b0;
    chk("ovf_pre", fetch_ovf, 1'b0);
    cyc();
    en_fetch = 1'b1; cyc(); en_fetch = 1'b0;
    chk("ovf_set", fetch_ovf, 1'b1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (en_ram_out || !mem_if.mem_req || mem_if.mem_addr != 8'h21) n++;
      cyc();
    end
    chk("ovf_wait_stable", n, 0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hBEEF;
    cyc();
    mem_if.mem_ack = 1'b0;
    chk("ovf_valid", {en_ram_out, mem_if.mem_req}, 2'b10);
    chk("ovf_ins", ins, 16'hBEEF);
    cyc();
    chk("ovf_single_pulse", en_ram_out, 1'b0);
    chk("ovf_sticky", fetch_ovf, 1'b1);

    // Ack in IDLE ignored
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h1234;
    cyc(); cyc();
    mem_if.mem_ack = 1'b0;
    chk("idle_ack_ins", ins, 16'hBEEF);
    chk("idle_ack_val", en_ram_out, 1'b0);

    // Back-to-back: fetch accepted in DONE
    en_fetch = 1'b1; cyc(); en_fetch = 1'b0;
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h0101;
    cyc();
    mem_if.mem_ack = 1'b0;
    en_fetch = 1'b1; cyc(); en_fetch = 1'b0;
    chk("b2b_req", {mem_if.mem_req, busy, en_ram_out}, 3'b110);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h0202;
    cyc();
    mem_if.mem_ack = 1'b0;
    chk("b2b_ins", {en_ram_out, ins}, {1'b1, 16'h0202});
    cyc();

    // en=0 blocks new fetch
    en = 1'b0; en_fetch = 1'b1; cyc(); en_fetch = 1'b0; en = 1'b1;
    chk("en0_nofetch", {mem_if.mem_req, busy}, 2'b00);

    // Never-acked request
    en_fetch = 1'b1; cyc(); en_fetch = 1'b0;
    n = 0;
    while (mem_if.mem_req && n < 40) begin
      cyc();
      n++;
    end
`ifdef FETCH_TIMEOUT_EN
    chk("to_cycles", n, 15);
    chk("to_valid", en_ram_out, 1'b1);
    chk("to_ins_nop", ins, 16'h0000);
    chk("to_err", fetch_err, 1'b1);
    cyc();
    chk("to_single_pulse", en_ram_out, 1'b0);
`else
    chk("noto_still_req", n, 40);
    chk("noto_err", fetch_err, 1'b0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h5A5A;
    cyc();
    mem_if.mem_ack = 1'b0;
    chk("noto_valid", {en_ram_out, ins}, {1'b1, 16'h5A5A});
    cyc();
`endif

    // Reset mid-fetch
    set_pc(8'h44);
    en_fetch = 1'b1; cyc(); en_fetch = 1'b0;
    chk("rstm_req", mem_if.mem_req, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("rstm_async_drop", {mem_if.mem_req, busy, pc}, {2'b00, 8'h00});
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hDEAD;
    cyc();
    rst = 1'b1;
    cyc();
    mem_if.mem_ack = 1'b0;
    chk("rstm_noval", {en_ram_out, mem_if.mem_req}, 2'b00);
    chk("rstm_state", {ins, pc, fetch_ovf, fetch_err}, {16'h0000, 8'h00, 2'b00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the control unit.
- Holds the PC and applies PC updates commanded by the control unit (en_pc_pulse, pc_ctrl, offset_addr).
- On a fetch pulse, reads the instruction memory at the current PC through a req/ack handshake.
- Returns the 16-bit instruction with a one-cycle valid pulse that feeds the control unit's ins / en_ram_out inputs.

Parameters:
ADDR_W, 8, PC and memory address width; offset_addr width equals ADDR_W.
DATA_W, 16, instruction width.
RESET_PC, 0, PC value loaded on reset.
TIMEOUT, 15, maximum cycles waiting for mem_ack; used only with FETCH_TIMEOUT_EN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low.
en  input  1  global enable; gates acceptance of new fetches and PC updates.
en_fetch  input  1  fetch request pulse from control unit (its en_ram_in).
en_pc_pulse  input  1  PC update pulse from control unit.
pc_ctrl  input  2  PC update select.
offset_addr  input  ADDR_W  jump target / relative offset from control unit.
mem_req  output  1  memory read request, held until ack.
mem_addr  output  ADDR_W  memory read address, stable while mem_req=1.
mem_ack  input  1  memory read acknowledge; mem_rdata valid in the same cycle.
mem_rdata  input  DATA_W  memory read data.
ins  output  DATA_W  last fetched instruction, held until the next fetch completes.
en_ram_out  output  1  one-cycle pulse: ins newly valid.
pc  output  ADDR_W  current program counter.
busy  output  1  high while a fetch is in flight (REQ state).
fetch_ovf  output  1  sticky: an en_fetch arrived while busy and was dropped.
fetch_err  output  1  sticky timeout flag; constant 0 when feature disabled.

Behaviour:
- Reset (rst=0, takes effect immediately): pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=0, ins=0, en_ram_out=0, busy=0, fetch_ovf=0, fetch_err=0, watchdog=0.
- Reset asserted mid-fetch aborts the request at once: mem_req drops asynchronously, and a late mem_ack is ignored.
- PC update on a clock edge with en=1 and en_pc_pulse=1:
  - 00: hold.
  - 01: pc+1.
  - 10: pc=offset_addr (absolute).
  - 11: pc=pc+sign_extend(offset_addr) (relative).
  - All arithmetic is modulo 2^ADDR_W; wrap is silent (0xFF+1 -> 0x00; 0x00 + 0xFF -> 0xFF).
- PC updates are accepted in any FSM state; an in-flight fetch is unaffected because mem_addr is latched.
- FSM states IDLE, REQ, DONE:
  - IDLE: when en=1 and en_fetch=1, latch mem_addr=pc (the value before any same-cycle PC update), set mem_req=1 and busy=1, go to REQ.
  - REQ: mem_req=1 and mem_addr stable. When mem_ack=1, capture ins=mem_rdata, drop mem_req, go to DONE. An ack sampled in the first REQ cycle is legal.
  - DONE: en_ram_out=1 for exactly this cycle, busy=0, return to IDLE. An en_fetch arriving in DONE is accepted as in IDLE (back-to-back fetches).
- Latency: en_fetch sampled at edge N -> mem_req high from cycle N+1. Ack sampled at edge M -> en_ram_out high in cycle M+1. Minimum is 2 cycles from request to valid.
- en_fetch while in REQ: dropped and fetch_ovf set (sticky until reset).
- en=0: no new fetch accepted and PC held; an in-flight REQ still completes normally.
- mem_ack while in IDLE/DONE: ignored.
- Simultaneous en_fetch and en_pc_pulse in IDLE: fetch uses the old PC, and pc takes the new value at the same edge.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A watchdog counts REQ cycles.
  - If TIMEOUT cycles elapse without mem_ack: mem_req drops, ins=0 (NOP), fetch_err is set sticky, and the FSM goes to DONE so en_ram_out still pulses once and the control unit does not hang.
  - The watchdog clears on every entry to REQ.
- Undefined: no watchdog; REQ waits indefinitely and fetch_err is tied 0.

Test Plan:
- Reset then en=1, en_fetch pulse, mem_ack one cycle later with mem_rdata=16'h1A05 -> mem_addr=0x00, ins=16'h1A05, en_ram_out high exactly 1 cycle, busy low after.
- pc=0x10; pc_ctrl=01 -> 0x11; pc_ctrl=10 with offset 0x80 -> 0x80; pc_ctrl=11 with offset 0xFE -> 0x7E; pc=0xFF with 01 -> 0x00.
- Same cycle en_fetch and en_pc_pulse (pc_ctrl=01) at pc=0x20 -> mem_addr=0x20, pc=0x21 next cycle.
- mem_ack delayed 5 cycles; second en_fetch during REQ -> mem_addr stable throughout, one en_ram_out only, fetch_ovf=1.
- rst pulled low in REQ, then ack arrives -> mem_req=0 immediately, no en_ram_out, pc=RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT=15, never ack -> mem_req drops after 15 REQ cycles, ins=0, en_ram_out pulses once, fetch_err=1.
